// File: rtl/icon_fetch_ctrl.sv
// rtl/icon_fetch_ctrl.sv - Rojobot sprite row prefetch into a line buffer, 2x-scaled icon replay.
// Optional ICON_SHADOW_EN: bot position/orientation captured only on frame_start.
module icon_fetch_ctrl #(
  parameter int ICON_SZ = 16,
  parameter int X_CORR  = 7,
  parameter int Y_CORR  = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic [9:0]  next_row,
  input  logic [9:0]  pixel_row,
  input  logic [9:0]  pixel_column,
  input  logic [7:0]  botinfo_reg,
  input  logic [7:0]  locx_reg,
  input  logic [7:0]  locy_reg,
  output logic [10:0] rom_addr,
  input  logic [1:0]  rom_data,
  output logic [1:0]  icon,
  output logic        busy,
  output logic        fetch_err
);

  localparam int CB = $clog2(ICON_SZ);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} stateT;

  stateT        state, stateNext;
  logic         loadFetch;
  logic         lineErr;

  logic [10:0]  leftS, topS;
  logic [2:0]   orientS;
  logic [10:0]  locxLeft, locyTop;
  logic [10:0]  curLeft, curTop;
  logic [2:0]   curOrient;
  logic         shadowLoad;

  logic [11:0]  rowDiff, colDiff;
  logic         rowHit, dispHit;

  logic [CB-1:0] col, capCol;
  logic          capValid;
  logic          bufValid;
  logic [10:0]   romAddr;
  logic [10:0]   dispLeft;
  logic          fetchErr;
  logic [1:0]    iconR;
  logic [1:0]    lineBuf [ICON_SZ];

  logic unusedBits;
  assign unusedBits = ^{pixel_row, botinfo_reg[7:3], next_row[0], pixel_column[0]};

  // Both corrections can push the icon edge negative; 11-bit two's complement covers it.
  assign locxLeft = {1'b0, locx_reg, 2'b00} - 11'(X_CORR);
  assign locyTop  = ({3'b000, locy_reg} + {2'b00, locy_reg, 1'b0}) - 11'(Y_CORR);

`ifdef ICON_SHADOW_EN
  assign shadowLoad = frame_start;
`else
  assign shadowLoad = frame_start | line_start;
`endif

  // Fresh values bypass the shadow so a same-cycle line_start fetch already sees them.
  assign curLeft   = shadowLoad ? locxLeft : leftS;
  assign curTop    = shadowLoad ? locyTop : topS;
  assign curOrient = shadowLoad ? botinfo_reg[2:0] : orientS;

  // Unsigned check of the upper bits folds 0 <= diff < ICON_SZ into one compare.
  assign rowDiff = {3'b000, next_row[9:1]} - {curTop[10], curTop};
  assign rowHit  = (rowDiff[11:CB] == '0);

  assign colDiff = {3'b000, pixel_column[9:1]} - {dispLeft[10], dispLeft};
  assign dispHit = bufValid && (colDiff[11:CB] == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    loadFetch = 1'b0;
    lineErr   = 1'b0;
    if (line_start) begin
      lineErr   = (state != IDLE);
      loadFetch = rowHit;
      stateNext = rowHit ? FETCH : IDLE;
    end else begin
      case (state)
        FETCH:   if (col == CB'(ICON_SZ - 1)) stateNext = DRAIN;
        DRAIN:   stateNext = IDLE;
        default: stateNext = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      leftS   <= '0;
      topS    <= '0;
      orientS <= '0;
    end else if (shadowLoad) begin
      leftS   <= locxLeft;
      topS    <= locyTop;
      orientS <= botinfo_reg[2:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col      <= '0;
      capCol   <= '0;
      capValid <= 1'b0;
      bufValid <= 1'b0;
      romAddr  <= '0;
      dispLeft <= '0;
      fetchErr <= 1'b0;
    end else begin
      fetchErr <= fetchErr | lineErr;
      if (line_start) begin
        bufValid <= 1'b0;
        capValid <= 1'b0;
        dispLeft <= curLeft;
        if (loadFetch) begin
          col     <= '0;
          romAddr <= {curOrient, rowDiff[CB-1:0], {CB{1'b0}}};
        end
      end else begin
        case (state)
          FETCH: begin
            capValid <= 1'b1;
            capCol   <= col;
            if (col != CB'(ICON_SZ - 1)) begin
              col            <= col + CB'(1);
              romAddr[CB-1:0] <= col + CB'(1);
            end
          end
          DRAIN: begin
            capValid <= 1'b0;
            bufValid <= 1'b1;
          end
          default: capValid <= 1'b0;
        endcase
      end
    end
  end

  // rom_data lags rom_addr by one clock, so the write uses the column issued last cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ICON_SZ; i++) lineBuf[i] <= '0;
    end else if (capValid) begin
      lineBuf[capCol] <= rom_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     iconR <= '0;
    else if (dispHit) iconR <= lineBuf[colDiff[CB-1:0]];
    else              iconR <= '0;
  end

  assign rom_addr  = romAddr;
  assign icon      = iconR;
  assign busy      = (state != IDLE);
  assign fetch_err = fetchErr;

endmodule
